// File: rtl/uart_boot_ctrl.sv
// Byte-stream boot/run controller: parses UART command packets into word writes,
// run sequencing and a one-byte acknowledge.
module uart_boot_ctrl #(
  parameter int unsigned RUN_DELAY = 100,
  parameter int unsigned TIMEOUT   = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_rd,
  input  logic [7:0]  rx_dout,
  output logic [31:0] insn_addr,
  output logic [31:0] insn_din,
  output logic        insn_we,
  output logic [31:0] data_addr,
  output logic [31:0] data_din,
  output logic        data_we,
  output logic        run,
  output logic [7:0]  ack_data,
  output logic        ack_valid,
  input  logic        ack_ready,
  output logic        busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_LEN      = 3'd2;
  localparam logic [2:0] S_DATA     = 3'd3;
  localparam logic [2:0] S_ACK      = 3'd4;
  localparam logic [2:0] S_RUN_WAIT = 3'd5;

  localparam logic [7:0] CMD_LOAD_INSN = 8'h01;
  localparam logic [7:0] CMD_LOAD_DATA = 8'h02;
  localparam logic [7:0] CMD_START     = 8'h03;
  localparam logic [7:0] CMD_STOP      = 8'h04;
  localparam logic [7:0] ACK_NAK       = 8'hEE;

  // The delay counter is preloaded so that run rises exactly RUN_DELAY cycles
  // after the accept cycle; delays below 2 are served straight from IDLE.
  localparam bit          SHORT_DELAY = (RUN_DELAY < 2);
  localparam logic [31:0] DELAY_LOAD  = SHORT_DELAY ? 32'd0 : 32'(RUN_DELAY - 2);
  localparam logic [31:0] IDLE_LAST   = 32'(TIMEOUT - 1);

  logic [2:0]  state;
  logic        rx_prev;
  logic [1:0]  byte_cnt;
  logic [7:0]  cmd;
  logic [31:0] base;
  logic [31:0] len;
  logic [31:0] shift;
  logic [31:0] idx;
  logic [31:0] idle_cnt;
  logic [31:0] delay_cnt;

  logic        byte_take;
  logic [31:0] base_next;
  logic [31:0] len_next;
  logic [31:0] word_next;
  logic [31:0] idx_next;
  logic [31:0] wr_addr;
  logic        timed_out;

  assign byte_take = rx_rd & ~rx_prev;
  assign base_next = {rx_dout, base[31:8]};
  assign len_next  = {rx_dout, len[31:8]};
  assign word_next = {rx_dout, shift[31:8]};
  assign idx_next  = idx + 32'd1;
  assign wr_addr   = base + {idx[29:0], 2'b00};
  assign timed_out = (idle_cnt == IDLE_LAST);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      rx_prev   <= 1'b0;
      byte_cnt  <= 2'd0;
      cmd       <= 8'h00;
      base      <= 32'h0;
      len       <= 32'h0;
      shift     <= 32'h0;
      idx       <= 32'h0;
      idle_cnt  <= 32'h0;
      delay_cnt <= 32'h0;
      insn_addr <= 32'h0;
      insn_din  <= 32'h0;
      insn_we   <= 1'b0;
      data_addr <= 32'h0;
      data_din  <= 32'h0;
      data_we   <= 1'b0;
      run       <= 1'b0;
      ack_data  <= 8'h00;
      ack_valid <= 1'b0;
    end else begin
      rx_prev <= rx_rd;
      insn_we <= 1'b0;
      data_we <= 1'b0;

      case (state)
        S_IDLE: begin
          if (byte_take) begin
            cmd      <= rx_dout;
            idle_cnt <= 32'h0;
            case (rx_dout)
              CMD_LOAD_INSN, CMD_LOAD_DATA: begin
                run      <= 1'b0;
                byte_cnt <= 2'd0;
                state    <= S_ADDR;
              end
              CMD_START: begin
                if (SHORT_DELAY) begin
                  run       <= 1'b1;
                  ack_data  <= 8'hA0 | CMD_START;
                  ack_valid <= 1'b1;
                  state     <= S_ACK;
                end else begin
                  delay_cnt <= DELAY_LOAD;
                  state     <= S_RUN_WAIT;
                end
              end
              CMD_STOP: begin
                run       <= 1'b0;
                ack_data  <= 8'hA0 | CMD_STOP;
                ack_valid <= 1'b1;
                state     <= S_ACK;
              end
              default: begin
                ack_data  <= ACK_NAK;
                ack_valid <= 1'b1;
                state     <= S_ACK;
              end
            endcase
          end
        end

        S_ADDR: begin
          if (byte_take) begin
            base     <= base_next;
            byte_cnt <= byte_cnt + 2'd1;
            idle_cnt <= 32'h0;
            if (byte_cnt == 2'd3)
              state <= S_LEN;
          end else if (timed_out) begin
            ack_data  <= ACK_NAK;
            ack_valid <= 1'b1;
            state     <= S_ACK;
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
          end
        end

        S_LEN: begin
          if (byte_take) begin
            len      <= len_next;
            byte_cnt <= byte_cnt + 2'd1;
            idle_cnt <= 32'h0;
            if (byte_cnt == 2'd3) begin
              idx <= 32'h0;
              if (len_next == 32'h0) begin
                ack_data  <= 8'hA0 | cmd;
                ack_valid <= 1'b1;
                state     <= S_ACK;
              end else begin
                state <= S_DATA;
              end
            end
          end else if (timed_out) begin
            ack_data  <= ACK_NAK;
            ack_valid <= 1'b1;
            state     <= S_ACK;
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
          end
        end

        S_DATA: begin
          if (byte_take) begin
            shift    <= word_next;
            byte_cnt <= byte_cnt + 2'd1;
            idle_cnt <= 32'h0;
            if (byte_cnt == 2'd3) begin
              if (cmd == CMD_LOAD_INSN) begin
                insn_addr <= wr_addr;
                insn_din  <= word_next;
                insn_we   <= 1'b1;
              end else begin
                data_addr <= wr_addr;
                data_din  <= word_next;
                data_we   <= 1'b1;
              end
              idx <= idx_next;
              if (idx_next == len) begin
                ack_data  <= 8'hA0 | cmd;
                ack_valid <= 1'b1;
                state     <= S_ACK;
              end
            end
          end else if (timed_out) begin
            // Partial word in the shift register is simply abandoned.
            ack_data  <= ACK_NAK;
            ack_valid <= 1'b1;
            state     <= S_ACK;
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
          end
        end

        S_RUN_WAIT: begin
          if (delay_cnt == 32'h0) begin
            run       <= 1'b1;
            ack_data  <= 8'hA0 | CMD_START;
            ack_valid <= 1'b1;
            state     <= S_ACK;
          end else begin
            delay_cnt <= delay_cnt - 32'd1;
          end
        end

        S_ACK: begin
          if (ack_ready) begin
            ack_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Directed bench for uart_boot_ctrl with short RUN_DELAY/TIMEOUT values.
module tb_uart_boot_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_rd;
  logic [7:0]  rx_dout;
  logic [31:0] insn_addr, insn_din, data_addr, data_din;
  logic        insn_we, data_we, run, ack_valid, ack_ready, busy;
  logic [7:0]  ack_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] ia_q[$];
  logic [31:0] id_q[$];
  logic [31:0] da_q[$];
  logic [31:0] dd_q[$];

  uart_boot_ctrl #(.RUN_DELAY(5), .TIMEOUT(10)) dut (
    .clk(clk), .reset(reset), .rx_rd(rx_rd), .rx_dout(rx_dout),
    .insn_addr(insn_addr), .insn_din(insn_din), .insn_we(insn_we),
    .data_addr(data_addr), .data_din(data_din), .data_we(data_we),
    .run(run), .ack_data(ack_data), .ack_valid(ack_valid),
    .ack_ready(ack_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (insn_we === 1'b1) begin
      ia_q.push_back(insn_addr);
      id_q.push_back(insn_din);
    end
    if (data_we === 1'b1) begin
      da_q.push_back(data_addr);
      dd_q.push_back(data_din);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    ia_q.delete(); id_q.delete(); da_q.delete(); dd_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dout = b;
    rx_rd   = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_bytes(input logic [7:0] bs[$]);
    foreach (bs[i]) send_byte(bs[i]);
  endtask

  task automatic wait_ack(input string tag, input logic [7:0] exp, input int hold);
    int n = 0;
    int unstable = 0;
    while (ack_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, {31'h0, ack_valid}, 32'h1);
    check({tag, "_data"}, {24'h0, ack_data}, {24'h0, exp});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (ack_valid !== 1'b1 || ack_data !== exp) unstable++;
    end
    if (hold > 0) check({tag, "_stable"}, unstable, 0);
    ack_ready = 1'b1;
    @(negedge clk);
    ack_ready = 1'b0;
    check({tag, "_busy_after"}, {31'h0, busy}, 32'h0);
    check({tag, "_valid_after"}, {31'h0, ack_valid}, 32'h0);
  endtask

  initial begin
    int n;
    int early;
    reset = 1'b1; rx_rd = 1'b0; rx_dout = 8'h00; ack_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_run", {31'h0, run}, 32'h0);
    check("rst_ack_valid", {31'h0, ack_valid}, 32'h0);
    check("rst_we", {30'h0, insn_we, data_we}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Two-word instruction load at 0x100.
    clear_log();
    send_bytes('{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
                 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
    wait_ack("insn_ack", 8'hA1, 0);
    check("insn_cnt", ia_q.size(), 2);
    check("data_cnt0", da_q.size(), 0);
    if (ia_q.size() == 2) begin
      check("insn_a0", ia_q[0], 32'h100);
      check("insn_d0", id_q[0], 32'h12345678);
      check("insn_a1", ia_q[1], 32'h104);
      check("insn_d1", id_q[1], 32'hDEADBEEF);
    end
    check("insn_hold", insn_din, 32'hDEADBEEF);

    // Zero-length data load with stalled acknowledge.
    clear_log();
    send_bytes('{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    wait_ack("zlen_ack", 8'hA2, 20);
    check("zlen_writes", ia_q.size() + da_q.size(), 0);

    // START: run rises exactly 5 cycles after the accept cycle.
    @(negedge clk);
    rx_dout = 8'h03;
    rx_rd   = 1'b1;
    early   = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) rx_rd = 1'b0;
      if (run !== 1'b0) early++;
    end
    @(negedge clk);
    check("start_early", early, 0);
    check("start_run", {31'h0, run}, 32'h1);
    wait_ack("start_ack", 8'hA3, 0);

    send_byte(8'h7F);
    wait_ack("unk_ack", 8'hEE, 0);
    check("unk_run", {31'h0, run}, 32'h1);

    send_byte(8'h04);
    wait_ack("stop_ack", 8'hA4, 0);
    check("stop_run", {31'h0, run}, 32'h0);

    // Timeout inside a data word.
    clear_log();
    send_bytes('{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hAA});
    n = 2;
    while (ack_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("to_window", {31'h0, (n >= 10 && n <= 11)}, 32'h1);
    wait_ack("to_ack", 8'hEE, 0);
    check("to_no_write", ia_q.size(), 0);
    check("to_run", {31'h0, run}, 32'h0);

    // Next packet parses normally; single data word at 0x8.
    clear_log();
    send_bytes('{8'h02, 8'h08, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                 8'h44, 8'h33, 8'h22, 8'h11});
    wait_ack("post_to_ack", 8'hA2, 0);
    check("post_to_cnt", da_q.size(), 1);
    if (da_q.size() == 1) begin
      check("post_to_a", da_q[0], 32'h8);
      check("post_to_d", dd_q[0], 32'h11223344);
    end
    check("post_to_insn", ia_q.size(), 0);

    // Address wrap past the top of the 32-bit space.
    clear_log();
    send_bytes('{8'h02, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00,
                 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00});
    wait_ack("wrap_ack", 8'hA2, 0);
    check("wrap_cnt", da_q.size(), 2);
    if (da_q.size() == 2) begin
      check("wrap_a0", da_q[0], 32'hFFFFFFFC);
      check("wrap_d0", dd_q[0], 32'h1);
      check("wrap_a1", da_q[1], 32'h0);
      check("wrap_d1", dd_q[1], 32'h2);
    end

    // Reset held 3 cycles mid-DATA.
    send_bytes('{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
                 8'h11, 8'h22});
    check("mid_busy", {31'h0, busy}, 32'h1);
    clear_log();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("mr_busy", {31'h0, busy}, 32'h0);
    check("mr_insn_addr", insn_addr, 32'h0);
    check("mr_data_addr", data_addr, 32'h0);
    check("mr_din", insn_din | data_din, 32'h0);
    check("mr_ack", {23'h0, ack_valid, ack_data}, 32'h0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("mr_no_strobe", ia_q.size() + da_q.size(), 0);
    check("mr_idle", {31'h0, busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_boot_ctrl.md
Name: uart_boot_ctrl

Overview:
- Packet-driven boot and run controller between `uart_rx` and the core's memory-load and run ports.
- Parses a byte stream into commands: load instruction words, load data words, start, stop.
- Generates word-wide writes with auto-incrementing addresses, sequences the core's `run` input with a start delay, and returns a one-byte acknowledge toward the UART transmit path.
- Replaces switch-based load/run selection.

Parameters:
- RUN_DELAY, 100, cycles between accepting a START command and asserting `run`.
- TIMEOUT, 50000000, maximum idle cycles between bytes inside a packet before the packet is aborted.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_rd  in  1  level from `uart_rx`; a byte is taken on its rising edge (rx_rd=1 while the previous-cycle sample was 0)
- rx_dout  in  8  received byte, valid when the rising edge is detected
- insn_addr  out  32  instruction write byte address
- insn_din  out  32  instruction write word
- insn_we  out  1  instruction write strobe, 1 cycle
- data_addr  out  32  data write byte address
- data_din  out  32  data write word
- data_we  out  1  data write strobe, 1 cycle
- run  out  1  core run enable
- ack_data  out  8  response byte
- ack_valid  out  1  response valid; held until accepted
- ack_ready  in  1  transmit side accepts `ack_data` when `ack_valid` and `ack_ready` are both 1
- busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, internal edge-detect register 0, counters 0. Reset mid-packet or mid-run behaves identically to power-up.
- Packet format:
  - CMD byte.
  - For CMD 0x01 (LOAD_INSN) and 0x02 (LOAD_DATA): 4-byte base address, then 4-byte word count N, both little-endian; then N words of 4 bytes each, little-endian.
  - 0x03 (START) and 0x04 (STOP) carry no payload.
- States: IDLE, ADDR, LEN, DATA, ACK, RUN_WAIT.
- IDLE, on a byte:
  - 0x01/0x02 → `run`←0, ADDR, byte counter←0.
  - 0x03 → delay counter←RUN_DELAY, RUN_WAIT.
  - 0x04 → `run`←0, ACK.
  - Any other value → ACK with NAK.
- ADDR and LEN: shift in 4 bytes each. After the 4th LEN byte: N=0 → ACK; otherwise DATA.
- DATA:
  - Shift-assemble with each new byte entering bits [31:24].
  - On the 4th byte of a word, in the next cycle: target address ← base + 4·index, target din ← the assembled word, target we=1 for exactly 1 cycle.
  - The non-target strobe stays 0.
  - After word N, go to ACK.
  - Address arithmetic is 32-bit modulo; wrap past 0xFFFFFFFC is allowed and not flagged.
- RUN_WAIT:
  - Decrement the delay counter each cycle; at 0, `run`←1 and go to ACK.
  - Bytes arriving in RUN_WAIT are dropped.
  - START while `run`=1 re-runs the delay without clearing `run`.
- ACK:
  - `ack_data` = 0xA0|CMD on success, 0xEE on NAK or unknown command. `ack_valid`=1.
  - Hold until the handshake; return to IDLE in the cycle after the handshake.
  - `ack_data` is stable while `ack_valid`=1.
  - Bytes received in ACK are dropped.
- Timeout (ADDR, LEN, DATA only):
  - Idle counter reset on every accepted byte.
  - Reaching TIMEOUT → discard the partial word, go to ACK with 0xEE.
  - Words already written stay written; `run` stays 0.
- `insn_addr`/`din` and `data_addr`/`din` hold their last value between strobes.
- `busy` is combinational from state.

Test Plan:
- Reset held 3 cycles mid-DATA → all outputs 0, state IDLE, no strobe after release.
- Bytes 01, 00 01 00 00, 02 00 00 00, then 78 56 34 12, EF BE AD DE → two `insn_we` pulses: addr 0x100 din 0x12345678, then addr 0x104 din 0xDEADBEEF; `data_we` never 1; `ack_data` 0xA1.
- Bytes 02, 00 00 00 00, 00 00 00 00 → no write strobes; `ack_data` 0xA2. Hold `ack_ready`=0 for 20 cycles → `ack_valid`/`ack_data` stable; after the handshake, `busy`=0 next cycle.
- Byte 03 with RUN_DELAY=5 → `run` rises exactly 5 cycles after the byte-accept cycle; `ack_data` 0xA3. Then byte 04 → `run`=0, `ack_data` 0xA4.
- Byte 7F → `ack_data` 0xEE, no state change to `run`.
- With TIMEOUT=10: bytes 01, 00 00 00 00, 01 00 00 00, AA, then silence → after 10 cycles `ack_data` 0xEE, no `insn_we`; the next packet is parsed correctly.
